// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read data memory between the processor port (0) and a
// loader/debug port (1): one access per cycle, round-robin or fixed priority, port-1 lock.
module dmem_port_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int P0_PRIORITY = 0
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam bit FIXED_PRIO = (P0_PRIORITY != 0);

    state_e            state_q, state_d;
    logic              last_winner_q, last_winner_d;
    logic              p0_gnt_q, p0_gnt_d;
    logic              p1_gnt_q, p1_gnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_tag_q, rd_tag_d;
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic p0_elig, p1_elig, lock_active, win0, win1;

    // A port whose grant is showing this cycle is still holding the old request.
    always_comb begin
        p0_elig     = p0_req & ~p0_gnt_q;
        p1_elig     = p1_req & ~p1_gnt_q;
        lock_active = (state_q == ST_LOCKED) & p1_lock;
        win0        = 1'b0;
        win1        = 1'b0;
        if (lock_active) begin
            win1 = p1_elig;
        end else if (p0_elig & p1_elig) begin
            if (FIXED_PRIO || last_winner_q) begin
                win0 = 1'b1;
            end else begin
                win1 = 1'b1;
            end
        end else begin
            win0 = p0_elig;
            win1 = p1_elig;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win1 & p1_lock) state_d = ST_LOCKED;
            ST_LOCKED: if (!p1_lock) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p0_gnt_d      = win0;
        p1_gnt_d      = win1;
        mem_en_d      = win0 | win1;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        last_winner_d = last_winner_q;
        if (win1) begin
            mem_we_d      = p1_we;
            mem_addr_d    = p1_addr;
            mem_wdata_d   = p1_wdata;
            last_winner_d = 1'b1;
        end else if (win0) begin
            mem_we_d      = p0_we;
            mem_addr_d    = p0_addr;
            mem_wdata_d   = p0_wdata;
            last_winner_d = 1'b0;
        end

        // Read tag follows the access one cycle behind, lining up with mem_rdata.
        rd_pend_d   = mem_en_q & ~mem_we_q;
        rd_tag_d    = p1_gnt_q;
        p0_rvalid_d = rd_pend_q & ~rd_tag_q;
        p1_rvalid_d = rd_pend_q & rd_tag_q;
        p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            last_winner_q <= 1'b1;
            p0_gnt_q      <= 1'b0;
            p1_gnt_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_tag_q      <= 1'b0;
            p0_rvalid_q   <= 1'b0;
            p1_rvalid_q   <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            p0_gnt_q      <= p0_gnt_d;
            p1_gnt_q      <= p1_gnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_pend_q     <= rd_pend_d;
            rd_tag_q      <= rd_tag_d;
            p0_rvalid_q   <= p0_rvalid_d;
            p1_rvalid_q   <= p1_rvalid_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
        end
    end

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_stall  = p0_req & ~p0_gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a round-robin and a fixed-priority instance share the
// stimulus; an event-scheduling model predicts every output cycle by cycle.
module tb_dmem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST_N;
    logic p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;

    logic [1:0] g0, g1, rv0, rv1, stall, men, mwe;
    logic [1:0][DW-1:0] rd0, rd1, mwd;
    logic [1:0][AW-1:0] maddr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    // Instance 0: round-robin, instance 1: fixed priority; each with its own memory.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [DW-1:0] mem [0:1023];
        logic [DW-1:0] rdq;
        always @(posedge CLK) begin
            if (men[gi]) begin
                if (mwe[gi]) mem[maddr[gi]] <= mwd[gi];
                else rdq <= mem[maddr[gi]];
            end
        end
        dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .P0_PRIORITY(gi)) u_dut (
            .CLK(CLK), .RST_N(RST_N),
            .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
            .p0_gnt(g0[gi]), .p0_rvalid(rv0[gi]), .p0_rdata(rd0[gi]), .p0_stall(stall[gi]),
            .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
            .p1_lock(p1_lock),
            .p1_gnt(g1[gi]), .p1_rvalid(rv1[gi]), .p1_rdata(rd1[gi]),
            .mem_en(men[gi]), .mem_we(mwe[gi]), .mem_addr(maddr[gi]), .mem_wdata(mwd[gi]),
            .mem_rdata(rdq)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic string inm(input int i, input string s);
        return {(i == 0) ? "rr." : "fp.", s};
    endfunction

    // Model: expected events are scheduled into an 8-entry ring indexed by cycle number.
    int cyc = 0;
    bit xg0 [2][8], xg1 [2][8], xen [2][8], xwe [2][8], xrv0 [2][8], xrv1 [2][8];
    logic [AW-1:0] xaddr [2][8];
    logic [DW-1:0] xwd [2][8], xrd0 [2][8], xrd1 [2][8];
    logic [DW-1:0] held0 [2], held1 [2];
    logic [DW-1:0] shadow [2][1024];
    bit mlock [2];
    bit mlw [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                xg0[i][k] = 0; xg1[i][k] = 0; xen[i][k] = 0; xwe[i][k] = 0;
                xrv0[i][k] = 0; xrv1[i][k] = 0;
            end
            held0[i] = '0; held1[i] = '0;
            mlock[i] = 0;
            mlw[i] = 1;
        end
    endtask

    initial begin : model
        int s, s1, s3, w;
        bit e0, e1, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
            end else begin
                s = cyc & 7; s1 = (cyc + 1) & 7; s3 = (cyc + 3) & 7;
                for (int i = 0; i < 2; i++) begin
                    e0 = p0_req && !xg0[i][s];
                    e1 = p1_req && !xg1[i][s];
                    w = -1;
                    if (mlock[i] && p1_lock) begin
                        if (e1) w = 1;
                    end else if (e0 && e1) w = (i == 1 || mlw[i]) ? 0 : 1;
                    else if (e0) w = 0;
                    else if (e1) w = 1;
                    if (w >= 0) begin
                        we = (w == 0) ? p0_we : p1_we;
                        a  = (w == 0) ? p0_addr : p1_addr;
                        d  = (w == 0) ? p0_wdata : p1_wdata;
                        if (w == 0) xg0[i][s1] = 1; else xg1[i][s1] = 1;
                        xen[i][s1] = 1; xwe[i][s1] = we; xaddr[i][s1] = a; xwd[i][s1] = d;
                        if (we) shadow[i][a] = d;
                        else if (w == 0) begin xrv0[i][s3] = 1; xrd0[i][s3] = shadow[i][a]; end
                        else begin xrv1[i][s3] = 1; xrd1[i][s3] = shadow[i][a]; end
                        mlw[i] = (w == 1);
                    end
                    mlock[i] = p1_lock && (mlock[i] || w == 1);
                    xg0[i][s] = 0; xg1[i][s] = 0; xen[i][s] = 0; xwe[i][s] = 0;
                    xrv0[i][s] = 0; xrv1[i][s] = 0;
                    if (xrv0[i][s1]) held0[i] = xrd0[i][s1];
                    if (xrv1[i][s1]) held1[i] = xrd1[i][s1];
                end
                cyc++;
            end
        end
    end

    initial begin : compare
        int c;
        forever begin
            @(negedge CLK);
            #2;
            c = cyc & 7;
            for (int i = 0; i < 2; i++) begin
                chk(inm(i, "p0_gnt"), 32'(g0[i]), 32'(xg0[i][c]));
                chk(inm(i, "p1_gnt"), 32'(g1[i]), 32'(xg1[i][c]));
                chk(inm(i, "mem_en"), 32'(men[i]), 32'(xen[i][c]));
                chk(inm(i, "mem_we"), 32'(mwe[i]), 32'(xwe[i][c]));
                if (xen[i][c]) begin
                    chk(inm(i, "mem_addr"), 32'(maddr[i]), 32'(xaddr[i][c]));
                    chk(inm(i, "mem_wdata"), mwd[i], xwd[i][c]);
                end
                chk(inm(i, "p0_rvalid"), 32'(rv0[i]), 32'(xrv0[i][c]));
                chk(inm(i, "p1_rvalid"), 32'(rv1[i]), 32'(xrv1[i][c]));
                chk(inm(i, "p0_rdata"), rd0[i], held0[i]);
                chk(inm(i, "p1_rdata"), rd1[i], held1[i]);
                chk(inm(i, "p0_stall"), 32'(stall[i]), 32'(p0_req && !xg0[i][c]));
            end
        end
    end

    initial begin : stim
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;

        // Reset held 3 cycles with a pending port-0 store.
        p0_req = 1; p0_we = 1; p0_addr = '0; p0_wdata = 32'h11;
        repeat (3) begin
            @(negedge CLK); #3;
            chk("rst gnt", 32'({g0, g1}), 32'h0);
            chk("rst rvalid", 32'({rv0, rv1}), 32'h0);
            chk("rst mem_en", 32'({men, mwe}), 32'h0);
            chk("rst rdata", rd0[0] | rd0[1] | rd1[0] | rd1[1], 32'h0);
            chk("rst mem_addr", 32'(maddr[0] | maddr[1]), 32'h0);
            chk("rst mem_wdata", mwd[0] | mwd[1], 32'h0);
        end
        @(negedge CLK); RST_N = 1'b1;
        #3 chk("rel p0_gnt early", 32'(g0), 32'h0);
        @(negedge CLK); #3 chk("rel p0_gnt", 32'(g0), 32'h3);

        // Loader writes mem[5], processor reads it back.
        @(negedge CLK);
        p0_req = 0; p1_req = 1; p1_we = 1; p1_addr = 10'd5; p1_wdata = 32'hAAAA5555;
        @(negedge CLK); #3;
        chk("wr p1_gnt", 32'(g1), 32'h3);
        chk("wr mem_we", 32'(mwe), 32'h3);
        chk("wr mem_addr", 32'(maddr[0]), 32'd5);
        chk("wr mem_wdata", mwd[1], 32'hAAAA5555);
        @(negedge CLK);
        p1_req = 0; p0_req = 1; p0_we = 0; p0_addr = 10'd5;
        @(negedge CLK); #3;
        chk("rd p0_gnt", 32'(g0), 32'h3);
        chk("rd mem_en", 32'(men), 32'h3);
        chk("rd mem_we", 32'(mwe), 32'h0);
        chk("rd mem_addr", 32'(maddr[1]), 32'd5);
        @(negedge CLK); p0_req = 0;
        #3 chk("rd rvalid early", 32'(rv0), 32'h0);
        @(negedge CLK); #3;
        chk("rd p0_rvalid", 32'(rv0), 32'h3);
        chk("rd p0_rdata", rd0[0], 32'hAAAA5555);
        chk("rd p1_rvalid", 32'(rv1), 32'h0);
        @(negedge CLK); #3;
        chk("rd rvalid pulse", 32'(rv0), 32'h0);
        chk("rd rdata hold", rd0[1], 32'hAAAA5555);

        // Contention: last winner is port 0, so round-robin picks port 1 first.
        @(negedge CLK);
        p0_req = 1; p0_we = 1; p0_addr = 10'd1; p0_wdata = 32'h01010101;
        p1_req = 1; p1_we = 1; p1_addr = 10'd2; p1_wdata = 32'h02020202;
        #3 chk("cont stall raise", 32'(stall), 32'h3);
        @(negedge CLK); #3;
        chk("cont1 p0_gnt", 32'(g0), 32'h2);
        chk("cont1 p1_gnt", 32'(g1), 32'h1);
        chk("cont1 stall", 32'(stall), 32'h1);
        @(negedge CLK); #3;
        chk("cont2 p0_gnt", 32'(g0), 32'h1);
        chk("cont2 p1_gnt", 32'(g1), 32'h2);
        chk("cont2 stall", 32'(stall), 32'h2);
        repeat (4) @(negedge CLK);
        @(negedge CLK); p0_req = 0; p1_req = 0;
        @(negedge CLK);

        // Preload 10..13 through port 1.
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            p1_req = 1; p1_we = 1; p1_addr = AW'(10 + k); p1_wdata = 32'h10000000 + k;
            @(negedge CLK);
        end
        @(negedge CLK); p1_req = 0;
        @(negedge CLK);

        // Locked burst of 4 reads; port 0 stalls until the lock drops.
        p1_req = 1; p1_we = 0; p1_addr = 10'd10; p1_lock = 1;
        @(negedge CLK);
        p0_req = 1; p0_we = 1; p0_addr = 10'd20; p0_wdata = 32'h2020;
        #3;
        chk("lock g1 #0", 32'(g1), 32'h3);
        chk("lock stall #0", 32'(stall), 32'h3);
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK); p1_addr = AW'(10 + k);
            #3;
            chk("lock gap gnt", 32'({g0, g1}), 32'h0);
            chk("lock gap stall", 32'(stall), 32'h3);
            @(negedge CLK); #3;
            chk("lock p1_gnt", 32'(g1), 32'h3);
            chk("lock stall", 32'(stall), 32'h3);
        end
        chk("lock p1_rvalid", 32'(rv1), 32'h3);
        chk("lock p1_rdata 12", rd1[0], 32'h10000002);
        @(negedge CLK); p1_lock = 0; p1_req = 0;
        #3;
        chk("unlock stall", 32'(stall), 32'h3);
        chk("unlock p1_gnt", 32'(g1), 32'h0);
        @(negedge CLK); #3;
        chk("unlock p0_gnt", 32'(g0), 32'h3);
        chk("unlock stall off", 32'(stall), 32'h0);
        chk("lock p1_rdata 13", rd1[1], 32'h10000003);
        @(negedge CLK); p0_req = 0;

        // Async reset while a locked port-1 read is in flight.
        @(negedge CLK);
        p1_req = 1; p1_we = 0; p1_addr = 10'd11; p1_lock = 1;
        @(negedge CLK); #3 chk("mid p1_gnt", 32'(g1), 32'h3);
        @(negedge CLK); p1_req = 0;
        #3 RST_N = 1'b0;
        @(negedge CLK);
        p0_req = 1; p0_we = 1; p0_addr = 10'd30; p0_wdata = 32'h3030;
        #3;
        chk("mid rvalid in reset", 32'(rv1), 32'h0);
        chk("mid gnt in reset", 32'({g0, g1}), 32'h0);
        RST_N = 1'b1;
        @(negedge CLK); #3;
        chk("post p0_gnt", 32'(g0), 32'h3);
        chk("post p1_gnt", 32'(g1), 32'h0);
        chk("post p1_rvalid", 32'(rv1), 32'h0);
        @(negedge CLK); p0_req = 0; p1_lock = 0;
        #3 chk("post p1_rvalid 2", 32'(rv1), 32'h0);
        @(negedge CLK); #3;
        chk("post p1_rvalid 3", 32'(rv1), 32'h0);
        chk("post p1_rdata", rd1[0] | rd1[1], 32'h0);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data memory between two requesters: port 0 is the processor load/store path, port 1 is a loader/debug port used to preload or inspect memory.
- Issues at most one word access per cycle to a synchronous-read memory, grants round-robin on contention, and supports a port-1 burst lock.
- Drives a stall flag so the processor can hold its PC while its access waits.

Parameters:
- ADDR_W, 10, word-address width (1024-word memory).
- DATA_W, 32, data width.
- P0_PRIORITY, 0, 1 = fixed priority to port 0 (lock still honoured); 0 = round-robin.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request, held until granted.
- p0_we  in  1  port 0 write enable (1 = store).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 store data.
- p0_gnt  out  1  port 0 access issued this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p0_stall  out  1  p0_req & ~p0_gnt (combinational).
- p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  port 1 request, same meaning as port 0.
- p1_lock  in  1  while high, port 1 keeps the grant across back-to-back requests.
- p1_gnt, p1_rvalid, p1_rdata  out  1/1/DATA_W  port 1 response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en & ~mem_we.

Behaviour:
- Reset (RST_N low, async):
  - All gnt/rvalid/mem_en/mem_we low.
  - rdata outputs and mem_addr/mem_wdata are 0.
  - last_winner = 1, so port 0 wins the first contention.
  - State = IDLE.
- FSM states:
  - IDLE: no lock held.
  - LOCKED: port 1 owns the memory.
  - IDLE -> LOCKED when p1 is granted with p1_lock = 1.
  - LOCKED -> IDLE on the first cycle p1_lock = 0, evaluated before arbitration in that cycle.
- Arbitration (combinational on the current cycle's req, registered outputs):
  - Only one req high: that port wins.
  - Both high in IDLE: if P0_PRIORITY = 1, port 0 wins; otherwise the port that is not last_winner wins.
  - LOCKED: port 1 wins if p1_req is high; port 0 is blocked even if port 1 is idle.
  - last_winner updates only on a grant.
- Grant timing:
  - Arbitration in cycle N; on the rising edge ending N, mem_en/mem_we/mem_addr/mem_wdata and the winner's gnt are registered, so they are visible in cycle N+1.
  - The requester sees gnt in cycle N+1 and must hold req/addr/data through N+1. It may deassert or present the next request in cycle N+2.
  - The arbiter must not grant the same port in consecutive cycles unless req was re-presented. It therefore ignores a port's req in the cycle its gnt is high. Throughput is one access per 2 cycles per port and one per cycle aggregate.
- Read return:
  - The arbiter tracks the winner of each read through a 1-deep tag pipeline.
  - Memory returns data in cycle N+2. That port's rvalid pulses for one cycle and rdata is registered from mem_rdata, so it is visible in cycle N+3.
  - rdata holds its value until the next rvalid for that port.
  - Writes produce no rvalid.
- Stall: p0_stall is high every cycle p0_req is high and p0_gnt is low. This includes the cycle the request is first raised and all lock-blocked cycles.
- Reset mid-operation:
  - An in-flight read is dropped: no rvalid after reset releases.
  - Lock is cleared.
- Simultaneous events:
  - lock release and p0_req in the same cycle: port 0 is eligible that cycle.
  - p1_lock high with p1_req low: no grant to port 1, and no entry into LOCKED.
- Addresses wider than memory are not possible (ADDR_W-bit); no wrap logic is needed.

Test Plan:
- Reset: hold RST_N low for 3 cycles while p0_req = 1 -> all gnt/rvalid/mem_en are 0 and rdata is 0; after release, p0_gnt rises exactly 1 cycle later.
- Single read: preload mem[5] = 0xAAAA5555, p0 read addr 5 -> mem_en = 1, mem_we = 0, mem_addr = 5 in N+1; p0_rvalid = 1 with p0_rdata = 0xAAAA5555 in N+3; p1_rvalid stays 0.
- Contention round-robin: both ports request continuously, p0 writes addr 1, p1 writes addr 2 -> grants alternate p0, p1, p0, p1 on consecutive cycles; p0_stall is high on every cycle port 0 is not granted.
- Lock: p1 with lock = 1 does 4 reads at addr 10..13 while p0_req = 1 -> 4 p1 grants, p0_stall high throughout; p0 is granted in the cycle after p1_lock drops.
- Fixed priority (P0_PRIORITY = 1): both request continuously -> p0 is granted every eligible cycle; p1 is granted only in cycles p0 is ineligible (the cycle after its own grant).
- Async reset mid-read: assert RST_N low 1 cycle after p1 is granted a read -> no p1_rvalid ever appears, and the lock state is IDLE.
